// File: rtl/pipeline_hazard_controller.sv
// Hazard/sequencing controller for the 5-stage pipeline: drives PC/IF_ID write
// enables and IF_ID/ID_EX/EX_MEM flushes for warm-up, load-use, taken branch
// (resolved in MEM) and the debug halt/drain handshake.
// Optional build macro: HAZARD_PERF_COUNTERS_EN adds saturating stall/flush
// performance counters; without it stall_count/flush_count read zero.
module pipeline_hazard_controller #(
  parameter int unsigned INIT_CYCLES  = 4,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rm,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  input  logic             halt_req,
  output logic             halt_ack,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned INIT_W  = 4;
  localparam int unsigned DRAIN_W = 3;
  localparam logic [4:0]         XZR        = 5'd31;
  localparam logic [INIT_W-1:0]  INIT_LAST  = INIT_W'(INIT_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STALL = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4,
    ST_HALT  = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [INIT_W-1:0]    init_cnt_q, init_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                 halt_ack_q, halt_ack_d;
  logic                 load_use_c;
  logic                 hold_c;

  // Load-use hazard: a load in EX writes a register the ID instruction reads (XZR excluded)
  always_comb begin
    load_use_c = ex_mem_read && (ex_rd != XZR) &&
                 ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
    hold_c     = (state_q == ST_DRAIN) || (state_q == ST_HALT);
  end

  // Next-state and control decode; priority is branch > load-use > halt
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;

    if (reset) begin
      state_d      = ST_INIT;
      init_cnt_d   = '0;
      drain_cnt_d  = '0;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (state_q == ST_INIT) begin
      // Warm-up: pipeline held and cleared, halt requests ignored
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      if (init_cnt_q == INIT_LAST) begin
        state_d    = ST_RUN;
        init_cnt_d = '0;
      end else begin
        init_cnt_d = init_cnt_q + 1'b1;
      end
    end else begin
      // Drain/halt freeze the front end and feed bubbles behind it
      if (hold_c) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end

      if (mem_branch_taken) begin
        // PC loads the branch target; everything younger than MEM is squashed
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        state_d      = ST_FLUSH;
      end else if (load_use_c) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b0;
        state_d      = ST_STALL;
      end else if (halt_req) begin
        case (state_q)
          ST_DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
              state_d     = ST_HALT;
              drain_cnt_d = '0;
            end else begin
              drain_cnt_d = drain_cnt_q + 1'b1;
            end
          end
          ST_HALT: state_d = ST_HALT;
          default: begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        endcase
      end else begin
        state_d = ST_RUN;
      end
    end

    halt_ack_d = (state_d == ST_HALT);
  end

  // State, sequencing counters and the registered halt acknowledge
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      drain_cnt_q <= '0;
      halt_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      halt_ack_q  <= halt_ack_d;
    end
  end

  assign state    = state_q;
  assign halt_ack = halt_ack_q;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counts; a branch hides a coincident load-use stall
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q != ST_INIT) begin
      if (mem_branch_taken) begin
        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
      end else if (load_use_c) begin
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule
